// File: rtl/bsg_misc_pkg.sv
// Shared definitions for the credit-pool family of blocks.
//   credit_state_e       : pool FSM encoding (RUN grants credits, DRAIN waits for all to return)
//   credit_count_width() : width of a credit counter that can hold 0..max_val inclusive
package bsg_misc_pkg;

  typedef enum logic {
    RUN_S   = 1'b0,
    DRAIN_S = 1'b1
  } credit_state_e;

  function automatic int credit_count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_credit_pool_rr.sv
// Round-robin one-hot selector.
//   clk_i, reset_i : clock / asynchronous active-high reset
//   reqs_i         : request vector
//   en_i           : advance enable; when low no grant is issued and the pointer holds
//   grant_o        : one-hot grant (all-zero when en_i is low or no request)
// The search starts one past the last granted index and wraps; after reset the
// last-granted index is els_p-1 so the first search begins at 0.
module bsg_credit_pool_rr #(
  parameter int els_p = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [els_p-1:0] reqs_i,
  input  logic             en_i,
  output logic [els_p-1:0] grant_o
);

  localparam int idx_w = $clog2(els_p);

  logic [idx_w-1:0] last_reg;
  logic [idx_w-1:0] last_next;
  logic [idx_w-1:0] cand_idx [els_p];
  logic             found;

  // cand_idx[k] is the k-th index visited by the search, in priority order.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_cand
    assign cand_idx[gi] = idx_w'((int'(last_reg) + gi + 1) % els_p);
  end

  always_comb begin
    grant_o   = '0;
    last_next = last_reg;
    found     = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      if (en_i && !found && reqs_i[cand_idx[k]]) begin
        grant_o[cand_idx[k]] = 1'b1;
        last_next            = cand_idx[k];
        found                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_reg <= idx_w'(els_p - 1);
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/bsg_credit_pool_arb.sv
// Shared credit pool with round-robin arbitration among els_p requesters.
//   clk_i, reset_i : clock / asynchronous active-high reset
//   v_i            : per-requester request valid
//   yumi_o         : one-hot grant, each grant consumes one credit this cycle
//   return_i       : credits returned this cycle (0..max_step_p)
//   drain_i        : level request to stop granting and wait for the pool to refill
//   drained_o      : in DRAIN with the pool full
//   count_o        : registered credit count
//   overflow_o     : sticky flag, returns pushed the count past max_val_p
module bsg_credit_pool_arb
  import bsg_misc_pkg::*;
#(
  parameter int els_p      = 4,
  parameter int max_val_p  = 16,
  parameter int init_val_p = 16,
  parameter int max_step_p = 2
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [els_p-1:0]                           v_i,
  output logic [els_p-1:0]                           yumi_o,
  input  logic [$clog2(max_step_p+1)-1:0]            return_i,
  input  logic                                       drain_i,
  output logic                                       drained_o,
  output logic [credit_count_width(max_val_p)-1:0]   count_o,
  output logic                                       overflow_o
);

  localparam int cnt_w = credit_count_width(max_val_p);
  localparam logic [cnt_w:0]   max_wide = (cnt_w+1)'(max_val_p);
  localparam logic [cnt_w-1:0] max_cnt  = cnt_w'(max_val_p);
  localparam logic [cnt_w-1:0] init_cnt = cnt_w'(init_val_p);

  credit_state_e    state_reg, state_next;
  logic [cnt_w-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             grant_ok;
  logic [cnt_w:0]   sum_wide;

  // Pool FSM: next state plus the grant permission, both from registered state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN_S:   if (drain_i)  state_next = DRAIN_S;
      DRAIN_S: if (!drain_i) state_next = RUN_S;
      default: state_next = RUN_S;
    endcase
    // Grants use only the registered count, so a same-cycle return is never granted.
    grant_ok = (state_reg == RUN_S) && (count_reg != '0) && !reset_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= RUN_S;
    end else begin
      state_reg <= state_next;
    end
  end

  bsg_credit_pool_rr #(
    .els_p(els_p)
  ) rr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .reqs_i (v_i),
    .en_i   (grant_ok),
    .grant_o(yumi_o)
  );

  // Up-down counter with one spare bit so an over-return is detectable before saturation.
  // A grant implies count_reg > 0, so the subtraction never underflows.
  always_comb begin
    sum_wide      = {1'b0, count_reg} - (cnt_w+1)'(|yumi_o) + (cnt_w+1)'(return_i);
    count_next    = sum_wide[cnt_w-1:0];
    overflow_next = overflow_reg;
    if (sum_wide > max_wide) begin
      count_next    = max_cnt;
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_reg    <= init_cnt;
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;
  assign drained_o  = (state_reg == DRAIN_S) && (count_reg == max_cnt) && !reset_i;

  // Returning more than max_step_p credits in one cycle is a protocol error upstream.
  a_return_step : assert property (@(posedge clk_i) disable iff (reset_i)
                                   return_i <= max_step_p);

endmodule
